keypad_scan_encoder: RTL and testbench

Matrix keypad front end for a 4x4 keypad. It drives the row lines one at a time and samples the column lines through a synchronizer. It debounces press and release with a consecutive-sample rule and emits a 4-bit key code with a one-cycle valid strobe per press. It sits between the keypad pins and the code-entry/lock logic, and is the upstream producer of debounced key events.

---
 rtl/keypad_scan_encoder.sv | 157 +++++++++++++++
 tb/tb_keypad_scan_encoder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_encoder.sv
// rtl/keypad_scan_encoder.sv - 4x4 keypad row scanner with press/release debounce and key code strobe
// Define KEYPAD_PHONE_MAP_EN to emit telephone-layout codes instead of raw {row, col}.
module keypad_scan_encoder #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_LEN = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] Col,
  output logic [3:0] Row,
  output logic [3:0] KeyCode,
  output logic       KeyValid,
  output logic       KeyHeld
);

  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {SCAN, PRESS_DB, REPORT, REL_DB} state_e;

  state_e        state_q, state_d;
  logic [3:0]    sync1_q, col_s_q;
  logic [TW-1:0] div_q, div_d;
  logic [1:0]    row_q, row_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    db_q, db_d;
  logic [3:0]    code_q, code_d;
  logic          held_q, held_d;
  logic          tick;
  logic          col_low;
  logic [1:0]    first_low;
  logic [3:0]    db_inc;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
`ifdef KEYPAD_PHONE_MAP_EN
    case ({r, c})
      4'h0:    key_code = 4'h1;
      4'h1:    key_code = 4'h2;
      4'h2:    key_code = 4'h3;
      4'h3:    key_code = 4'hA;
      4'h4:    key_code = 4'h4;
      4'h5:    key_code = 4'h5;
      4'h6:    key_code = 4'h6;
      4'h7:    key_code = 4'hB;
      4'h8:    key_code = 4'h7;
      4'h9:    key_code = 4'h8;
      4'hA:    key_code = 4'h9;
      4'hB:    key_code = 4'hC;
      4'hC:    key_code = 4'hE;
      4'hD:    key_code = 4'h0;
      4'hE:    key_code = 4'hF;
      default: key_code = 4'hD;
    endcase
`else
    key_code = {r, c};
`endif
  endfunction

  assign tick    = (div_q == TW'(SCAN_DIV - 1));
  assign col_low = ~col_s_q[col_q];
  assign db_inc  = db_q + 4'd1;

  always_comb begin
    first_low = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col_s_q[i]) first_low = 2'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + TW'(1);
    row_d   = row_q;
    col_d   = col_q;
    db_d    = db_q;
    code_d  = code_q;
    held_d  = held_q;
    case (state_q)
      SCAN: begin
        if (tick) begin
          if (col_s_q != 4'hF) begin
            col_d   = first_low;
            db_d    = 4'd1;
            state_d = PRESS_DB;
          end else begin
            row_d = row_q + 2'd1;
          end
        end
      end
      PRESS_DB: begin
        if (tick) begin
          if (col_low) begin
            db_d = db_inc;
            // Code and held flag load on entry so they are visible alongside the strobe.
            if (db_inc == 4'(DEBOUNCE_LEN)) begin
              code_d  = key_code(row_q, col_q);
              held_d  = 1'b1;
              state_d = REPORT;
            end
          end else begin
            db_d    = 4'd0;
            state_d = SCAN;
          end
        end
      end
      REPORT: begin
        db_d    = 4'd0;
        state_d = REL_DB;
      end
      REL_DB: begin
        if (tick) begin
          if (!col_low) begin
            db_d = db_inc;
            if (db_inc == 4'(DEBOUNCE_LEN)) begin
              held_d  = 1'b0;
              db_d    = 4'd0;
              row_d   = row_q + 2'd1;
              state_d = SCAN;
            end
          end else begin
            db_d = 4'd0;
          end
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= SCAN;
      sync1_q <= 4'hF;
      col_s_q <= 4'hF;
      div_q   <= '0;
      row_q   <= 2'd0;
      col_q   <= 2'd0;
      db_q    <= 4'd0;
      code_q  <= 4'd0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= Col;
      col_s_q <= sync1_q;
      div_q   <= div_d;
      row_q   <= row_d;
      col_q   <= col_d;
      db_q    <= db_d;
      code_q  <= code_d;
      held_q  <= held_d;
    end
  end

  assign Row      = ~(4'b0001 << row_q);
  assign KeyCode  = code_q;
  assign KeyValid = (state_q == REPORT);
  assign KeyHeld  = held_q;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// tb/tb_keypad_scan_encoder.sv - directed and randomized keypad scenarios against a tick-level keypad model
module tb_keypad_scan_encoder;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 4;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [3:0]  Col;
  logic [3:0]  Row;
  logic [3:0]  KeyCode;
  logic        KeyValid;
  logic        KeyHeld;
  logic [15:0] pressed = '0;

  int checks = 0;
  int errors = 0;
  int valid_seen = 0;
  logic [3:0] last_code = '0;

  int         m_row, m_col, m_streak;
  bit         m_pending, m_held, m_valid;
  logic [3:0] m_code;

  keypad_scan_encoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_LEN(DEB)) dut (
    .Clock(Clock), .Reset(Reset), .Col(Col), .Row(Row),
    .KeyCode(KeyCode), .KeyValid(KeyValid), .KeyHeld(KeyHeld)
  );

  always #5 Clock = ~Clock;

  // Switch matrix: a pressed key shorts its column to its row when that row is driven low.
  always_comb begin
    Col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && (Row[r] === 1'b0)) Col[c] = 1'b0;
  end

  function automatic logic [15:0] key(input int r, input int c);
    return 16'(1) << (r*4 + c);
  endfunction

  function automatic logic [3:0] map_code(input int r, input int c);
`ifdef KEYPAD_PHONE_MAP_EN
    if (c == 3) return 4'(10 + r);
    if (r < 3)  return 4'(r*3 + c + 1);
    if (c == 0) return 4'hE;
    if (c == 1) return 4'h0;
    return 4'hF;
`else
    return 4'(r*4 + c);
`endif
  endfunction

  task automatic model_reset();
    m_row = 0; m_col = 0; m_streak = 0;
    m_pending = 0; m_held = 0; m_valid = 0; m_code = '0;
  endtask

  // One scan tick: the sample is whatever the held keys show on the currently driven row.
  task automatic model_tick(input logic [15:0] keys);
    logic [3:0] low;
    low = keys[m_row*4 +: 4];
    m_valid = 0;
    if (m_held) begin
      if (low[m_col]) m_streak = 0;
      else begin
        m_streak++;
        if (m_streak == DEB) begin
          m_held = 0; m_streak = 0; m_row = (m_row + 1) % 4;
        end
      end
    end else if (m_pending) begin
      if (low[m_col]) begin
        m_streak++;
        if (m_streak == DEB) begin
          m_pending = 0; m_held = 1; m_valid = 1; m_streak = 0;
          m_code = map_code(m_row, m_col);
        end
      end else begin
        m_pending = 0; m_streak = 0;
      end
    end else if (low != 4'h0) begin
      m_col = 3;
      for (int c = 3; c >= 0; c--) if (low[c]) m_col = c;
      m_pending = 1; m_streak = 1;
    end else begin
      m_row = (m_row + 1) % 4;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0] er;
    er = 4'hF;
    er[m_row] = 1'b0;
    checks++;
    assert (Row === er) else begin errors++; $error("FAIL %s Row got %b want %b", tag, Row, er); end
    checks++;
    assert (KeyValid === m_valid) else begin errors++; $error("FAIL %s KeyValid got %b want %b", tag, KeyValid, m_valid); end
    checks++;
    assert (KeyHeld === m_held) else begin errors++; $error("FAIL %s KeyHeld got %b want %b", tag, KeyHeld, m_held); end
    checks++;
    assert (KeyCode === m_code) else begin errors++; $error("FAIL %s KeyCode got %h want %h", tag, KeyCode, m_code); end
    if (KeyValid === 1'b1) begin
      valid_seen++;
      last_code = KeyCode;
    end
  endtask

  // Called at the falling edge of the first cycle of a row dwell; returns at the same point of the next.
  task automatic run_tick(input logic [15:0] keys);
    pressed = keys;
    check_outputs("dwell0");
    m_valid = 0;
    repeat (SCAN_DIV - 1) begin
      @(negedge Clock);
      check_outputs("dwell");
    end
    model_tick(keys);
    @(negedge Clock);
  endtask

  task automatic hold(input logic [15:0] keys, input int n);
    for (int i = 0; i < n; i++) run_tick(keys);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    pressed = '0;
    @(negedge Clock);
    model_reset();
    check_outputs("reset");
    Reset = 1'b0;
  endtask

  task automatic expect_events(input string tag, input int base, input int n, input logic [3:0] code);
    checks++;
    assert (valid_seen - base == n) else begin
      errors++; $error("FAIL %s events got %0d want %0d", tag, valid_seen - base, n);
    end
    if (n > 0) begin
      checks++;
      assert (last_code === code) else begin
        errors++; $error("FAIL %s code got %h want %h", tag, last_code, code);
      end
    end
  endtask

  initial begin
    int base;
    int r, c, nb, nh, ng;
    logic [15:0] k;

    model_reset();
    repeat (3) @(negedge Clock);
    check_outputs("por");
    Reset = 1'b0;

    base = valid_seen;
    hold('0, 32);
    expect_events("idle", base, 0, 4'h0);

    base = valid_seen;
    hold(key(1, 2), 40);
    hold('0, 8);
`ifdef KEYPAD_PHONE_MAP_EN
    expect_events("clean_1_2", base, 1, 4'h6);
`else
    expect_events("clean_1_2", base, 1, 4'h6);
`endif

    base = valid_seen;
    for (int i = 0; i < 10; i++) run_tick((i % 2 == 0) ? key(3, 0) : 16'h0);
    expect_events("bounce_only", base, 0, 4'h0);
    hold(key(3, 0), 10);
    hold('0, 8);
`ifdef KEYPAD_PHONE_MAP_EN
    expect_events("bounce_3_0", base, 1, 4'hE);
`else
    expect_events("bounce_3_0", base, 1, 4'hC);
`endif

    base = valid_seen;
    hold(key(0, 1) | key(0, 3), 12);
    hold(key(0, 1), 6);
    checks++;
    assert (KeyHeld === 1'b1) else begin errors++; $error("FAIL two_key held got %b want 1", KeyHeld); end
    hold('0, 8);
`ifdef KEYPAD_PHONE_MAP_EN
    expect_events("two_key", base, 1, 4'h2);
`else
    expect_events("two_key", base, 1, 4'h1);
`endif

    base = valid_seen;
    hold(key(2, 2), 12);
    hold('0, 3);
    hold(key(2, 2), 1);
    hold('0, 3);
    checks++;
    assert (KeyHeld === 1'b1) else begin errors++; $error("FAIL glitch held got %b want 1", KeyHeld); end
    hold('0, 5);
    expect_events("glitch_2_2", base, 1, map_code(2, 2));

    for (int round = 0; round < 20; round++) begin
      r  = $urandom_range(0, 3);
      c  = $urandom_range(0, 3);
      k  = key(r, c);
      if ($urandom_range(0, 3) == 0) k = k | key(r, $urandom_range(0, 3));
      nb = $urandom_range(0, 6);
      nh = $urandom_range(8, 20);
      ng = $urandom_range(0, 3);
      base = valid_seen;
      for (int i = 0; i < nb; i++) run_tick((i % 2 == 0) ? k : 16'h0);
      hold(k, nh);
      if ($urandom_range(0, 1) == 1) begin
        hold('0, ng);
        hold(k, 1);
      end
      hold('0, 6);
      checks++;
      assert (valid_seen - base == 1) else begin
        errors++; $error("FAIL random round %0d events got %0d want 1", round, valid_seen - base);
      end
    end

    hold(key(2, 1), 10);
    checks++;
    assert (KeyHeld === 1'b1) else begin errors++; $error("FAIL pre_reset held got %b want 1", KeyHeld); end
    do_reset();
    base = valid_seen;
    hold('0, 12);
    expect_events("after_reset", base, 0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
